ex_mem_pipe: RTL and testbench

//   Elastic EX->MEM pipeline register, the successor to the fixed EX/MEM latch.

---
 rtl/ex_mem_pipe.sv | 183 ++++++++++++++++++
 tb/tb_ex_mem_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe.sv
// Elastic EX->MEM pipeline register with valid/ready handshake, flush, bubble
// suppression, optional two-entry skid buffer and a saturating stall counter.
module ex_mem_pipe #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int FUNCT3_WIDTH  = 3,
    parameter int SKID          = 1,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ValidE,
    output logic                     ReadyE,
    input  logic                     RegWriteE,
    input  logic [1:0]               ResultSrcE,
    input  logic                     MemWriteE,
    input  logic [DATA_WIDTH-1:0]    ALUResultE,
    input  logic [DATA_WIDTH-1:0]    WriteDataE,
    input  logic [ADDRESS_WIDTH-1:0] RdE,
    input  logic [DATA_WIDTH-1:0]    PCPlus4E,
    input  logic [FUNCT3_WIDTH-1:0]  funct3E,
    input  logic                     FlushM,
    input  logic                     ReadyM,
    output logic                     ValidM,
    output logic                     RegWriteM,
    output logic [1:0]               ResultSrcM,
    output logic                     MemWriteM,
    output logic [DATA_WIDTH-1:0]    ALUResultM,
    output logic [DATA_WIDTH-1:0]    WriteDataM,
    output logic [ADDRESS_WIDTH-1:0] RdM,
    output logic [DATA_WIDTH-1:0]    PCPlus4M,
    output logic [FUNCT3_WIDTH-1:0]  funct3M,
    output logic [CNT_WIDTH-1:0]     StallCntM
);

    localparam int PW = 4 + 3 * DATA_WIDTH + ADDRESS_WIDTH + FUNCT3_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [PW-1:0]        pl_in_s;
    logic [PW-1:0]        h_data_r;
    logic                 h_valid_s;
    logic                 ready_s;
    logic                 accept_s;
    logic                 pop_s;
    logic                 rw_h_s;
    logic                 mw_h_s;
    logic [CNT_WIDTH-1:0] stall_cnt_r;

    assign pl_in_s  = {RegWriteE, ResultSrcE, MemWriteE, ALUResultE, WriteDataE,
                       RdE, PCPlus4E, funct3E};
    assign accept_s = ValidE & ready_s & ~FlushM;
    assign pop_s    = h_valid_s & ReadyM;

    generate
        if (SKID == 0) begin : g_single
            logic valid_r;

            assign h_valid_s = valid_r;
            assign ready_s   = (~valid_r | ReadyM) & ~RST;

            // Single holding register: load on accept, drain on pop
            always_ff @(posedge CLK) begin
                if (RST) begin
                    valid_r  <= 1'b0;
                    h_data_r <= {PW{1'b0}};
                end else if (FlushM) begin
                    valid_r <= 1'b0;
                end else if (accept_s) begin
                    valid_r  <= 1'b1;
                    h_data_r <= pl_in_s;
                end else if (pop_s) begin
                    valid_r <= 1'b0;
                end
            end
        end else begin : g_skid
            localparam logic [1:0] ST_EMPTY = 2'b00;
            localparam logic [1:0] ST_ONE   = 2'b01;
            localparam logic [1:0] ST_TWO   = 2'b10;

            logic [1:0]    state_r;
            logic [1:0]    state_nxt_s;
            logic [PW-1:0] s_data_r;
            logic          ready_r;
            logic          load_h_s;
            logic          load_s_s;
            logic          h_from_s_s;

            assign h_valid_s = (state_r != ST_EMPTY);
            // ReadyE comes from a flop so MEM-side ready never reaches EX combinationally
            assign ready_s   = ready_r & ~RST;

            // Occupancy transitions and entry-load selects
            always_comb begin
                state_nxt_s = state_r;
                load_h_s    = 1'b0;
                load_s_s    = 1'b0;
                h_from_s_s  = 1'b0;
                case (state_r)
                    ST_EMPTY: begin
                        if (accept_s) begin
                            state_nxt_s = ST_ONE;
                            load_h_s    = 1'b1;
                        end else begin
                            state_nxt_s = ST_EMPTY;
                        end
                    end
                    ST_ONE: begin
                        if (accept_s & pop_s) begin
                            load_h_s = 1'b1;
                        end else if (accept_s) begin
                            state_nxt_s = ST_TWO;
                            load_s_s    = 1'b1;
                        end else if (pop_s) begin
                            state_nxt_s = ST_EMPTY;
                        end else begin
                            state_nxt_s = ST_ONE;
                        end
                    end
                    ST_TWO: begin
                        if (pop_s) begin
                            state_nxt_s = ST_ONE;
                            h_from_s_s  = 1'b1;
                        end else begin
                            state_nxt_s = ST_TWO;
                        end
                    end
                    default: begin
                        state_nxt_s = ST_EMPTY;
                    end
                endcase
            end

            // State and registered ready; flush empties both entries
            always_ff @(posedge CLK) begin
                if (RST) begin
                    state_r <= ST_EMPTY;
                    ready_r <= 1'b1;
                end else if (FlushM) begin
                    state_r <= ST_EMPTY;
                    ready_r <= 1'b1;
                end else begin
                    state_r <= state_nxt_s;
                    ready_r <= (state_nxt_s != ST_TWO);
                end
            end

            // Head and skid payload storage
            always_ff @(posedge CLK) begin
                if (RST) begin
                    h_data_r <= {PW{1'b0}};
                    s_data_r <= {PW{1'b0}};
                end else begin
                    if (load_h_s) begin
                        h_data_r <= pl_in_s;
                    end else if (h_from_s_s) begin
                        h_data_r <= s_data_r;
                    end
                    if (load_s_s) begin
                        s_data_r <= pl_in_s;
                    end
                end
            end
        end
    endgenerate

    // Saturating count of cycles the head waits on MEM
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (h_valid_s & ~ReadyM & ~FlushM & (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_WIDTH'(1);
        end
    end

    assign {rw_h_s, ResultSrcM, mw_h_s, ALUResultM, WriteDataM, RdM, PCPlus4M, funct3M} = h_data_r;
    // Write enables are gated so a bubble can never commit state
    assign RegWriteM = h_valid_s & rw_h_s;
    assign MemWriteM = h_valid_s & mw_h_s;
    assign ValidM    = h_valid_s;
    assign ReadyE    = ready_s;
    assign StallCntM = stall_cnt_r;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: three instances (skid, skid with 2-bit counter, single
// entry) checked every cycle against a queue-level model plus literal expectations.
module tb_ex_mem_pipe;

    typedef struct packed {
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [2:0]  f3;
    } pl_t;

    logic CLK = 1'b0;
    logic RST, ValidE, FlushM, ReadyM;
    pl_t  in_pl;

    logic        valid_w [3];
    logic        ready_w [3];
    pl_t         pl_w    [3];
    logic [15:0] cnt_w   [3];

    int  n_pass  = 0;
    int  n_total = 0;
    bit  chk_en  = 1'b0;

    pl_t mbuf   [3][2];
    int  mcnt   [3];
    int  mstall [3];
    bit  mrst   [3];

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int SKV = (g == 2) ? 0 : 1;
        localparam int CWV = (g == 1) ? 2 : 16;
        logic v_o, r_o, rw_o, mw_o;
        logic [1:0] rs_o;
        logic [31:0] alu_o, wd_o, pc_o;
        logic [4:0] rd_o;
        logic [2:0] f3_o;
        logic [CWV-1:0] cnt_o;

        ex_mem_pipe #(.SKID(SKV), .CNT_WIDTH(CWV)) u_dut (
            .CLK(CLK), .RST(RST), .ValidE(ValidE), .ReadyE(r_o),
            .RegWriteE(in_pl.rw), .ResultSrcE(in_pl.rs), .MemWriteE(in_pl.mw),
            .ALUResultE(in_pl.alu), .WriteDataE(in_pl.wd), .RdE(in_pl.rd),
            .PCPlus4E(in_pl.pc), .funct3E(in_pl.f3),
            .FlushM(FlushM), .ReadyM(ReadyM), .ValidM(v_o),
            .RegWriteM(rw_o), .ResultSrcM(rs_o), .MemWriteM(mw_o),
            .ALUResultM(alu_o), .WriteDataM(wd_o), .RdM(rd_o),
            .PCPlus4M(pc_o), .funct3M(f3_o), .StallCntM(cnt_o)
        );

        assign valid_w[g] = v_o;
        assign ready_w[g] = r_o;
        assign pl_w[g]    = {rw_o, rs_o, mw_o, alu_o, wd_o, rd_o, pc_o, f3_o};
        assign cnt_w[g]   = 16'(cnt_o);
    end

    function automatic bit skid_of(int i);
        return (i != 2);
    endfunction

    function automatic int cmax_of(int i);
        return (i == 1) ? 3 : 65535;
    endfunction

    function automatic bit model_ready(int i);
        if (RST) return 1'b0;
        if (skid_of(i)) return (mcnt[i] < 2);
        return (mcnt[i] == 0) || ReadyM;
    endfunction

    task automatic check(string nm, int idx, logic [127:0] act, logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, idx, act, exp, $time);
    endtask

    // FIFO-level model: capacity 2 (skid) or 1, flush empties, reset clears all
    always @(posedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            if (RST) begin
                mcnt[i]   = 0;
                mstall[i] = 0;
                mrst[i]   = 1'b1;
            end else begin
                bit acc, pop;
                acc = ValidE && model_ready(i) && !FlushM;
                pop = (mcnt[i] > 0) && ReadyM;
                if ((mcnt[i] > 0) && !ReadyM && !FlushM && (mstall[i] < cmax_of(i)))
                    mstall[i]++;
                if (FlushM) begin
                    mcnt[i] = 0;
                end else begin
                    if (pop) begin
                        mbuf[i][0] = mbuf[i][1];
                        mcnt[i]--;
                    end
                    if (acc) begin
                        mbuf[i][mcnt[i]] = in_pl;
                        mcnt[i]++;
                        mrst[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every instance against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check("ValidM", i, 128'(valid_w[i]), 128'(mcnt[i] > 0));
                check("ReadyE", i, 128'(ready_w[i]), 128'(model_ready(i)));
                check("StallCntM", i, 128'(cnt_w[i]), 128'(mstall[i]));
                if (mcnt[i] > 0) begin
                    check("payload", i, 128'(pl_w[i]), 128'(mbuf[i][0]));
                end else begin
                    check("bubble_we", i, 128'({pl_w[i].rw, pl_w[i].mw}), 128'(0));
                end
                if (mrst[i]) check("rst_payload", i, 128'(pl_w[i]), 128'(0));
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    int s1_exp [3] = '{32'h10, 32'h14, 32'h18};
    int s6_exp [6] = '{1, 2, 3, 3, 3, 3};

    initial begin
        RST = 1'b1; ValidE = 1'b0; FlushM = 1'b0; ReadyM = 1'b0; in_pl = '0;
        step();
        chk_en = 1'b1;
        step();
        #1;
        check("rst_valid", 0, 128'(valid_w[0]), 128'(0));
        check("rst_ready", 0, 128'(ready_w[0]), 128'(0));
        check("rst_alu", 0, 128'(pl_w[0].alu), 128'(0));
        check("rst_cnt", 0, 128'(cnt_w[0]), 128'(0));
        RST = 1'b0;
        #1;
        check("rel_ready", 0, 128'(ready_w[0]), 128'(1));

        // Back-to-back stream with MEM always ready
        ValidE = 1'b1; ReadyM = 1'b1; in_pl.alu = 32'h10;
        for (int k = 0; k < 3; k++) begin
            step();
            if (k < 2) in_pl.alu = 32'(s1_exp[k + 1]);
            else ValidE = 1'b0;
            #1;
            check("s1_alu", 0, 128'(pl_w[0].alu), 128'(s1_exp[k]));
            check("s1_alu", 2, 128'(pl_w[2].alu), 128'(s1_exp[k]));
            check("s1_ready", 0, 128'(ready_w[0]), 128'(1));
        end
        step();
        #1;
        check("s1_drain", 0, 128'(valid_w[0]), 128'(0));
        check("s1_drain", 2, 128'(valid_w[2]), 128'(0));

        // Fill the skid buffer while MEM stalls, then release
        ReadyM = 1'b0; ValidE = 1'b1; in_pl.rw = 1'b1; in_pl.mw = 1'b1; in_pl.alu = 32'h100;
        step();
        in_pl.alu = 32'h200;
        #1;
        check("s2_readyA", 0, 128'(ready_w[0]), 128'(1));
        check("s2_mw", 0, 128'(pl_w[0].mw), 128'(1));
        step();
        ValidE = 1'b0;
        #1;
        check("s2_readyB", 0, 128'(ready_w[0]), 128'(0));
        check("s2_cnt1", 0, 128'(cnt_w[0]), 128'(1));
        step();
        step();
        #1;
        check("s2_headA", 0, 128'(pl_w[0].alu), 128'(32'h100));
        check("s2_cnt3", 0, 128'(cnt_w[0]), 128'(3));
        ReadyM = 1'b1;
        step();
        #1;
        check("s2_headB", 0, 128'(pl_w[0].alu), 128'(32'h200));
        step();
        #1;
        check("s2_empty", 0, 128'(valid_w[0]), 128'(0));

        // Flush while full with a new payload offered
        ReadyM = 1'b0; ValidE = 1'b1; in_pl.alu = 32'h110;
        step();
        in_pl.alu = 32'h120;
        step();
        in_pl.alu = 32'h300; FlushM = 1'b1;
        #1;
        check("s3_full", 0, 128'(ready_w[0]), 128'(0));
        step();
        FlushM = 1'b0; ValidE = 1'b0; ReadyM = 1'b1;
        #1;
        check("s3_valid", 0, 128'(valid_w[0]), 128'(0));
        check("s3_ready", 0, 128'(ready_w[0]), 128'(1));
        check("s3_mw", 0, 128'(pl_w[0].mw), 128'(0));
        check("s3_cnt", 0, 128'(cnt_w[0]), 128'(4));
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            check("s3_noC", 0, 128'(valid_w[0]), 128'(0));
        end

        // Flush beats an accept that would otherwise succeed
        ValidE = 1'b1; ReadyM = 1'b0; in_pl.alu = 32'h350;
        step();
        in_pl.alu = 32'h400; FlushM = 1'b1; ReadyM = 1'b1;
        #1;
        check("fl_ready", 0, 128'(ready_w[0]), 128'(1));
        check("fl_ready", 2, 128'(ready_w[2]), 128'(1));
        step();
        FlushM = 1'b0; ValidE = 1'b0;
        #1;
        check("fl_valid", 0, 128'(valid_w[0]), 128'(0));
        check("fl_valid", 2, 128'(valid_w[2]), 128'(0));

        // Bubbles with write enables asserted on the EX side
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            check("s4_rw", 0, 128'(pl_w[0].rw), 128'(0));
            check("s4_mw", 0, 128'(pl_w[0].mw), 128'(0));
        end

        // Reset while holding a valid entry
        ValidE = 1'b1; in_pl.rd = 5'd5; ReadyM = 1'b0;
        step();
        #1;
        check("s5_rd", 0, 128'(pl_w[0].rd), 128'(5));
        RST = 1'b1;
        #1;
        check("s5_ready_rst", 0, 128'(ready_w[0]), 128'(0));
        step();
        ValidE = 1'b0;
        #1;
        check("s5_valid", 0, 128'(valid_w[0]), 128'(0));
        check("s5_payload", 0, 128'(pl_w[0]), 128'(0));
        check("s5_cnt", 0, 128'(cnt_w[0]), 128'(0));
        RST = 1'b0;
        #1;
        check("s5_ready_rel", 0, 128'(ready_w[0]), 128'(1));

        // Counter saturation on the 2-bit instance
        ValidE = 1'b1; in_pl.alu = 32'h600; ReadyM = 1'b0;
        step();
        ValidE = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            #1;
            check("s6_cnt", 1, 128'(cnt_w[1]), 128'(s6_exp[k]));
        end
        ReadyM = 1'b1;
        step();
        step();
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
